// File: rtl/mem_responder.sv
// mem_responder: unified word-addressed memory serving fetch (i_*) and data (d_*) ports
// over a req/ack handshake with WAIT_CYCLES wait states. Optional feature macro: MEM_RANGE_CHECK_EN.
module mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        busy,
    output logic        err
);
    localparam int         DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic                    accept;
    logic                    owner_d;
    logic                    resp;
    logic [31:0]             req_addr;
    logic                    req_oor;

    logic                    lat_we;
    logic                    lat_oor;
    logic [DEPTH_LOG2-1:0]   lat_idx;
    logic [31:0]             lat_wdata;

    logic [31:0]             mem [DEPTH];
    logic [31:0]             read_word;
    logic [31:0]             i_rdata_q, d_rdata_q;

    // Data port wins when both requests are present in IDLE
    assign accept   = (state == S_IDLE) && (d_req || i_req);
    assign req_addr = d_req ? d_addr : i_addr;

`ifdef MEM_RANGE_CHECK_EN
    assign req_oor = (req_addr[31:DEPTH_LOG2] != '0);
`else
    logic unused_addr_hi;
    assign req_oor        = 1'b0;
    assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2];
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept)            owner_d   <= d_req;
            if (i_ack)             i_rdata_q <= read_word;
            if (d_ack && !lat_we)  d_rdata_q <= read_word;
        end
    end

    // Request fields are captured once at accept; later input changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= d_req && d_we;
            lat_oor   <= req_oor;
            lat_idx   <= req_addr[DEPTH_LOG2-1:0];
            lat_wdata <= d_wdata;
        end
    end

    // Store commits at the edge that ends RESP; a reset in that cycle cancels it
    always_ff @(posedge clk) begin
        if (d_ack && lat_we && !lat_oor) mem[lat_idx] <= lat_wdata;
    end

    assign resp      = (state == S_RESP) && reset;
    assign read_word = lat_oor ? 32'h0 : mem[lat_idx];
    assign i_ack     = resp && !owner_d;
    assign d_ack     = resp && owner_d;
    assign err       = resp && lat_oor;
    assign busy      = (state != S_IDLE);
    assign i_rdata   = i_ack ? read_word : i_rdata_q;
    assign d_rdata   = (d_ack && !lat_we) ? read_word : d_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized fetch/load/store traffic checked against
// a simple array model; a second instance with WAIT_CYCLES=0 checks back-to-back timing.
module tb_mem_responder;
`ifdef MEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, busy, err;
    logic [31:0] i_rdata, d_rdata;

    logic        i_req0, d_req0, d_we0;
    logic [31:0] i_addr0, d_addr0, d_wdata0;
    logic        i_ack0, d_ack0, busy0, err0;
    logic [31:0] i_rdata0, d_rdata0;

    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy), .err(err)
    );

    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .i_req(i_req0), .i_addr(i_addr0), .i_ack(i_ack0), .i_rdata(i_rdata0),
        .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
        .d_ack(d_ack0), .d_rdata(d_rdata0), .busy(busy0), .err(err0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        we;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        q_i[$];
    exp_t        q_d[$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] last_i = 32'h0;
    logic [31:0] last_d = 32'h0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: word array, index = address modulo depth, optional out-of-range rule
    function automatic exp_t model(logic we, logic [31:0] addr, logic [31:0] wdata);
        exp_t e;
        int   idx = int'(addr % 32'd1024);
        bit   oor = RANGE_EN && (addr >= 32'd1024);
        e.we  = we;
        e.err = oor;
        e.rdata = 32'h0;
        if (we) begin
            if (!oor) ref_mem[idx] = wdata;
        end else begin
            e.rdata = oor ? 32'h0 : ref_mem[idx];
        end
        return e;
    endfunction

    // Monitor: pops expectations whenever the DUT acknowledges
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (i_ack && d_ack) check("both_acks", {i_ack, d_ack}, 2'b00);
                if (i_ack) begin
                    if (q_i.size() == 0) begin
                        check("i_ack_unexpected", i_ack, 1'b0);
                    end else begin
                        e = q_i.pop_front();
                        check("i_rdata", i_rdata, e.rdata);
                        check("i_err", err, e.err);
                        check("d_rdata_hold_on_i", d_rdata, last_d);
                        last_i = e.rdata;
                    end
                end
                if (d_ack) begin
                    if (q_d.size() == 0) begin
                        check("d_ack_unexpected", d_ack, 1'b0);
                    end else begin
                        e = q_d.pop_front();
                        if (e.we) begin
                            check("d_rdata_hold_on_store", d_rdata, last_d);
                        end else begin
                            check("d_rdata", d_rdata, e.rdata);
                            last_d = e.rdata;
                        end
                        check("d_err", err, e.err);
                        check("i_rdata_hold_on_d", i_rdata, last_i);
                    end
                end
                if (!i_ack && !d_ack && err) check("err_without_ack", err, 1'b0);
            end
        end
    end

    task automatic wait_ack(bit dport, bit scramble, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (scramble && n == 1) begin
                if (dport) begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                    d_we    = 1'($urandom);
                end else begin
                    i_addr = $urandom;
                end
            end
            if (dport ? d_ack : i_ack) break;
            if (n > 20) begin
                check(dport ? "d_ack_timeout" : "i_ack_timeout", 32'(n), 32'd3);
                break;
            end
        end
    endtask

    task automatic issue_d(logic we, logic [31:0] addr, logic [31:0] wdata, bit scramble);
        int n;
        @(negedge clk);
        check("busy_idle_d", busy, 1'b0);
        q_d.push_back(model(we, addr, wdata));
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        wait_ack(1'b1, scramble, n);
        check("d_latency", 32'(n), 32'd3);
        d_req = 1'b0;
    endtask

    task automatic issue_i(logic [31:0] addr, bit scramble);
        int n;
        @(negedge clk);
        check("busy_idle_i", busy, 1'b0);
        q_i.push_back(model(1'b0, addr, 32'h0));
        i_req = 1'b1; i_addr = addr;
        wait_ack(1'b0, scramble, n);
        check("i_latency", 32'(n), 32'd3);
        i_req = 1'b0;
    endtask

    task automatic issue_both(logic we, logic [31:0] daddr, logic [31:0] wdata,
                              logic [31:0] iaddr, bit scramble);
        int n;
        @(negedge clk);
        check("busy_idle_both", busy, 1'b0);
        q_d.push_back(model(we, daddr, wdata));
        q_i.push_back(model(1'b0, iaddr, 32'h0));
        d_req = 1'b1; d_we = we; d_addr = daddr; d_wdata = wdata;
        i_req = 1'b1; i_addr = iaddr;
        wait_ack(1'b1, scramble, n);
        check("both_d_latency", 32'(n), 32'd3);
        d_req = 1'b0;
        wait_ack(1'b0, 1'b0, n);
        check("both_i_after_d", 32'(n), 32'd4);
        i_req = 1'b0;
    endtask

    function automatic logic [31:0] gen_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
        return a;
    endfunction

    initial begin : stim
        int n;
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        i_req0 = 1'b0; i_addr0 = 32'h0;
        d_req0 = 1'b0; d_we0 = 1'b0; d_addr0 = 32'h0; d_wdata0 = 32'h0;

        // Reset held with a fetch request pending
        repeat (3) begin
            @(negedge clk);
            check("rst_i_ack", i_ack, 1'b0);
            check("rst_d_ack", d_ack, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_err", err, 1'b0);
            check("rst_i_rdata", i_rdata, 32'h0);
            check("rst_d_rdata", d_rdata, 32'h0);
        end
        i_req = 1'b0;
        reset = 1'b1;

        for (int k = 0; k < 16; k++) issue_d(1'b1, 32'(k), $urandom, 1'b0);

        // Store then fetch the same word
        issue_d(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
        issue_i(32'd5, 1'b0);

        // Simultaneous requests: data first, fetch follows
        issue_both(1'b0, 32'd5, 32'h0, 32'd5, 1'b0);

        // Upper address bits: wrap, or range error when enabled
        issue_d(1'b0, 32'h405, 32'h0, 1'b0);
        issue_d(1'b1, 32'h405, 32'hCAFE_F00D, 1'b0);
        issue_d(1'b0, 32'd5, 32'h0, 1'b0);

        // Reset during WAIT abandons a store
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h1234;
        @(negedge clk);
        check("busy_in_wait", busy, 1'b1);
        reset = 1'b0; d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("busy_after_rst", busy, 1'b0);
        check("i_rdata_after_rst", i_rdata, 32'h0);
        check("d_rdata_after_rst", d_rdata, 32'h0);
        last_i = 32'h0;
        last_d = 32'h0;
        issue_d(1'b0, 32'd7, 32'h0, 1'b0);

        // Random traffic; request inputs are scrambled after accept
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 2))
                0:       issue_d(1'(($urandom_range(0, 1))), gen_addr(), $urandom, 1'b1);
                1:       issue_i(gen_addr(), 1'b1);
                default: issue_both(1'(($urandom_range(0, 1))), gen_addr(), $urandom, gen_addr(), 1'b1);
            endcase
        end

        // Zero-wait instance: ack next cycle, held request re-served two cycles later
        @(negedge clk);
        i_req0 = 1'b1; i_addr0 = 32'd3;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            forever begin
                @(negedge clk);
                n++;
                if (i_ack0 || n > 10) break;
            end
            check(r == 0 ? "w0_first_ack" : "w0_second_ack", 32'(n), r == 0 ? 32'd1 : 32'd2);
            check("w0_d_ack", d_ack0, 1'b0);
            check("w0_err", err0, 1'b0);
        end
        i_req0 = 1'b0;

        repeat (4) @(negedge clk);
        check("q_i_empty", 32'(q_i.size()), 32'd0);
        check("q_d_empty", 32'(q_d.size()), 32'd0);
        check("busy_end", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
